// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory controller port between instruction fetch and data access.
// Optional ARB_PERF_EN adds grant and fetch-wait performance counters.
module mem_port_arbiter #(
  parameter int XLEN     = 64,
  parameter int D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_req,
  input  logic [31:0]     imem_addr,
  input  logic            imem_abort,
  output logic            imem_ready,
  output logic            imem_valid,
  output logic [XLEN-1:0] imem_data,
  output logic            imem_err,
  input  logic            dmem_read_req,
  input  logic            dmem_write_req,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [2:0]      dmem_size,
  input  logic            dmem_signed,
  output logic            dmem_ready,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_error,
  output logic            port_req,
  output logic            port_we,
  output logic [XLEN-1:0] port_addr,
  output logic [XLEN-1:0] port_wdata,
  output logic [2:0]      port_size,
  output logic            port_signed,
  input  logic            port_ack,
  input  logic [XLEN-1:0] port_rdata,
  input  logic            port_err,
  output logic [1:0]      fsm_state
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]     perf_i_grants,
  output logic [31:0]     perf_d_grants,
  output logic [31:0]     perf_i_wait_cycles
`endif
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "mem_port_arbiter: XLEN must be 32 or 64");
    end
    if (D_STREAK < 1 || D_STREAK > 15) begin : g_bad_streak
      $fatal(1, "mem_port_arbiter: D_STREAK must be 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            owner_i;
  logic            drop;
  logic [3:0]      streak;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;
  logic            dreq;
  logic            data_win;
  logic            fetch_win;
  logic            in_grant;

  assign dreq     = dmem_read_req | dmem_write_req;
  assign in_grant = (state == GRANT_I) || (state == GRANT_D);

  // Handshake: port_req rises on the grant edge and holds every port_* field
  // steady until the single-cycle port_ack; the owner then sees one pulse.
  always_comb begin
    state_nxt = state;
    data_win  = 1'b0;
    fetch_win = 1'b0;
    case (state)
      IDLE: begin
        data_win  = dreq && (!imem_req || (streak < 4'(D_STREAK)));
        fetch_win = !data_win && imem_req && !imem_abort;
        if (data_win)
          state_nxt = GRANT_D;
        else if (fetch_win)
          state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: if (port_ack) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_i     <= 1'b0;
      drop        <= 1'b0;
      streak      <= 4'd0;
      port_req    <= 1'b0;
      port_we     <= 1'b0;
      port_addr   <= '0;
      port_wdata  <= '0;
      port_size   <= 3'b000;
      port_signed <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (data_win) begin
        // data_win with a waiting fetch implies streak < D_STREAK, so this saturates
        owner_i     <= 1'b0;
        port_req    <= 1'b1;
        port_we     <= dmem_write_req;
        port_addr   <= dmem_addr;
        port_wdata  <= dmem_wdata;
        port_size   <= dmem_size;
        port_signed <= dmem_signed;
        streak      <= imem_req ? streak + 4'd1 : 4'd0;
      end else if (fetch_win) begin
        owner_i     <= 1'b1;
        port_req    <= 1'b1;
        port_we     <= 1'b0;
        port_addr   <= XLEN'(imem_addr);
        port_wdata  <= '0;
        port_size   <= 3'b010;
        port_signed <= 1'b0;
        streak      <= 4'd0;
      end
      if (in_grant && port_ack) begin
        port_req  <= 1'b0;
        resp_data <= port_rdata;
        resp_err  <= port_err;
      end
      if (state == GRANT_I && imem_abort)
        drop <= 1'b1;
      else if (state == RESP)
        drop <= 1'b0;
    end
  end

  // A flush in the response cycle itself must also swallow the pulse.
  assign imem_ready = (state == IDLE);
  assign imem_valid = (state == RESP) && owner_i && !drop && !imem_abort;
  assign imem_data  = resp_data;
  assign imem_err   = imem_valid && resp_err;
  assign dmem_ready = (state == RESP) && !owner_i;
  assign dmem_rdata = resp_data;
  assign dmem_error = dmem_ready && resp_err;
  assign fsm_state  = state;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(dmem_read_req && dmem_write_req));

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_grants      <= 32'd0;
      perf_d_grants      <= 32'd0;
      perf_i_wait_cycles <= 32'd0;
    end else begin
      if (fetch_win)
        perf_i_grants <= perf_i_grants + 32'd1;
      if (data_win)
        perf_d_grants <= perf_d_grants + 32'd1;
      if (imem_req && !fetch_win)
        perf_i_wait_cycles <= perf_i_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed corner cases plus randomized concurrent
// fetch/data traffic against a transaction-level model and response scoreboard.
module tb_mem_port_arbiter;
  localparam int XLEN     = 64;
  localparam int D_STREAK = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req = 1'b0;
  logic [31:0]     imem_addr = '0;
  logic            imem_abort = 1'b0;
  logic            imem_ready, imem_valid, imem_err;
  logic [XLEN-1:0] imem_data;
  logic            dmem_read_req = 1'b0, dmem_write_req = 1'b0;
  logic [XLEN-1:0] dmem_addr = '0, dmem_wdata = '0;
  logic [2:0]      dmem_size = '0;
  logic            dmem_signed = 1'b0;
  logic            dmem_ready, dmem_error;
  logic [XLEN-1:0] dmem_rdata;
  logic            port_req, port_we, port_signed;
  logic [XLEN-1:0] port_addr, port_wdata;
  logic [2:0]      port_size;
  logic            port_ack = 1'b0;
  logic [XLEN-1:0] port_rdata = '0;
  logic            port_err = 1'b0;
  logic [1:0]      fsm_state;
`ifdef ARB_PERF_EN
  logic [31:0]     perf_i_grants, perf_d_grants, perf_i_wait_cycles;
`endif

  mem_port_arbiter #(.XLEN(XLEN), .D_STREAK(D_STREAK)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_abort(imem_abort),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_data(imem_data), .imem_err(imem_err),
    .dmem_read_req(dmem_read_req), .dmem_write_req(dmem_write_req), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_size(dmem_size), .dmem_signed(dmem_signed),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_size(port_size), .port_signed(port_signed), .port_ack(port_ack),
    .port_rdata(port_rdata), .port_err(port_err), .fsm_state(fsm_state)
`ifdef ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_i_wait_cycles(perf_i_wait_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0] exp_i_q[$];
  logic [64:0] exp_d_q[$];
  logic        grant_log[$];
  logic        auto_ack = 1'b0;

  logic [31:0] cur_i_addr = '0;
  logic        cur_d_we = 1'b0;
  logic [63:0] cur_d_addr = '0, cur_d_wdata = '0;
  logic [2:0]  cur_d_size = '0;
  logic        cur_d_signed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream memory: read data and error are a pure function of the address.
  function automatic logic [64:0] mem_model(input logic [63:0] a);
    logic [63:0] d;
    d = a * 64'h9E37_79B9_7F4A_7C15 + 64'h13;
    return {(a[3:0] == 4'hF), d};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_fetch(input logic [31:0] a);
    logic got;
    got = 1'b0;
    cur_i_addr = a;
    imem_addr  = a;
    imem_req   = 1'b1;
    exp_i_q.push_back(mem_model({32'h0, a}));
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = imem_valid;
    end
    check("fetch_done", got, 1);
    @(posedge clk); #1;
    imem_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [2:0] sz, input logic sg);
    logic got;
    got = 1'b0;
    cur_d_we = we; cur_d_addr = a; cur_d_wdata = wd; cur_d_size = sz; cur_d_signed = sg;
    dmem_write_req = we;
    dmem_read_req  = !we;
    dmem_addr      = a;
    dmem_wdata     = wd;
    dmem_size      = sz;
    dmem_signed    = sg;
    exp_d_q.push_back(mem_model(a));
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = dmem_ready;
    end
    check("data_done", got, 1);
    @(posedge clk); #1;
    dmem_read_req  = 1'b0;
    dmem_write_req = 1'b0;
  endtask

  // Automatic responder with random 0..3 cycle acknowledge latency.
  initial begin
    int dly;
    dly = -1;
    forever begin
      @(posedge clk); #1;
      if (auto_ack) begin
        port_ack = 1'b0;
        if (port_req) begin
          if (dly < 0) dly = $urandom_range(0, 3);
          if (dly == 0) begin
            port_ack   = 1'b1;
            port_rdata = mem_model(port_addr)[63:0];
            port_err   = mem_model(port_addr)[64];
            dly        = -1;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (!reset) begin
      if (imem_valid) begin
        if (exp_i_q.size() == 0) check("imem_unexpected", imem_valid, 0);
        else begin
          e = exp_i_q.pop_front();
          check("imem_data", imem_data, e[63:0]);
          check("imem_err", imem_err, e[64]);
        end
      end
      if (dmem_ready) begin
        if (exp_d_q.size() == 0) check("dmem_unexpected", dmem_ready, 0);
        else begin
          e = exp_d_q.pop_front();
          check("dmem_rdata", dmem_rdata, e[63:0]);
          check("dmem_error", dmem_error, e[64]);
        end
      end
    end
  end

  // ---------------- arbitration / timing model ----------------
  logic p_req = 0, p_ack = 0, p_idle = 0, p_ireq = 0, p_dreq = 0, p_abort = 0, p_rst = 1;
  logic owner_i_m = 0, drop_m = 0;
  int   ms = 0;

  always @(negedge clk) begin
    logic is_fetch, data_first, exp_pulse;
    if (reset) begin
      ms = 0; drop_m = 0; p_rst = 1;
    end else begin
      exp_pulse = p_ack && p_req && !p_rst;
      if (exp_pulse || imem_valid || dmem_ready) begin
        check("imem_valid_timing", imem_valid, exp_pulse && owner_i_m && !drop_m && !imem_abort);
        check("dmem_ready_timing", dmem_ready, exp_pulse && !owner_i_m);
      end
      if (port_req && !p_req) begin
        is_fetch   = (port_addr[63:32] == 32'h0);
        data_first = p_dreq && (!p_ireq || ms < D_STREAK);
        check("grant_owner", is_fetch, !data_first);
        grant_log.push_back(is_fetch);
        owner_i_m = is_fetch;
        drop_m    = 1'b0;
        if (is_fetch) begin
          ms = 0;
          check("fetch_addr", port_addr, {32'h0, cur_i_addr});
          check("fetch_we", port_we, 0);
          check("fetch_size", port_size, 3'b010);
          check("fetch_signed", port_signed, 0);
        end else begin
          ms = p_ireq ? ((ms < D_STREAK) ? ms + 1 : D_STREAK) : 0;
          check("data_addr", port_addr, cur_d_addr);
          check("data_we", port_we, cur_d_we);
          check("data_size", port_size, cur_d_size);
          check("data_signed", port_signed, cur_d_signed);
          if (cur_d_we) check("data_wdata", port_wdata, cur_d_wdata);
        end
      end else if (!port_req && !p_rst && p_idle && (p_dreq || (p_ireq && !p_abort))) begin
        check("grant_taken", port_req, 1);
      end
      if (port_req && owner_i_m && imem_abort) drop_m = 1'b1;
      p_rst = 0;
    end
    p_req   = port_req;
    p_ack   = port_ack;
    p_idle  = imem_ready;
    p_ireq  = imem_req;
    p_dreq  = dmem_read_req | dmem_write_req;
    p_abort = imem_abort;
  end

  function automatic logic [15:0] pack_log();
    logic [15:0] v;
    v = '0;
    foreach (grant_log[i]) v = {v[14:0], grant_log[i]};
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    imem_req = 0; imem_abort = 0; dmem_read_req = 0; dmem_write_req = 0; port_ack = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic seen;
    do_reset();
    @(negedge clk);
    check("rst_imem_ready", imem_ready, 1);
    check("rst_port_req", port_req, 0);
    check("rst_imem_valid", imem_valid, 0);
    check("rst_dmem_ready", dmem_ready, 0);
    check("rst_imem_data", imem_data, 0);
    check("rst_dmem_rdata", dmem_rdata, 0);
    check("rst_port_addr", port_addr, 0);
    check("rst_port_we", port_we, 0);

    // Lone fetch, manual ack one cycle after port_req.
    @(posedge clk); #1;
    cur_i_addr = 32'h8000_0000; imem_addr = 32'h8000_0000; imem_req = 1'b1;
    exp_i_q.push_back({1'b0, 64'h13});
    @(negedge clk); check("lone_no_req_yet", port_req, 0);
    @(posedge clk); #1; port_ack = 1'b1; port_rdata = 64'h13; port_err = 1'b0;
    @(negedge clk); check("lone_port_req_n1", port_req, 1);
    @(posedge clk); #1; port_ack = 1'b0;
    @(negedge clk);
    check("lone_imem_valid_n2", imem_valid, 1);
    check("lone_imem_data_n2", imem_data, 64'h13);
    check("lone_port_req_drop", port_req, 0);
    @(posedge clk); #1; imem_req = 1'b0;
    auto_ack = 1'b1;

    // Simultaneous fetch and load: data first.
    grant_log.delete();
    fork
      do_fetch(32'h0000_2000);
      do_data(1'b0, 64'h4000_0000_0000_0100, 64'h0, 3'b011, 1'b0);
    join
    check("both_count", grant_log.size(), 2);
    check("both_order", pack_log(), 16'b01);

    // Back-to-back loads with a fetch pending: streak limit.
    do_reset();
    @(posedge clk); #1;
    grant_log.delete();
    fork
      do_fetch(32'h0000_1000);
      for (int k = 0; k < 6; k++)
        do_data(1'b0, 64'h4000_0000_0000_0000 + 64'(k * 8), 64'h0, 3'b010, 1'b1);
    join
    check("streak_count", grant_log.size(), 7);
    check("streak_order", pack_log(), 16'b0000100);

    // Abort while the fetch is granted; the ack must not reach the fetch stage.
    auto_ack = 1'b0;
    cur_i_addr = 32'h0000_3000; imem_addr = 32'h0000_3000; imem_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = port_req;
    end
    check("abort_grant_seen", seen, 1);
    imem_abort = 1'b1; port_ack = 1'b1; port_rdata = 64'hDEAD; port_err = 1'b0;
    @(posedge clk); #1;
    imem_abort = 1'b0; port_ack = 1'b0; imem_req = 1'b0;
    @(negedge clk); check("abort_no_valid", imem_valid, 0);
    @(posedge clk); #1;
    auto_ack = 1'b1;
    do_fetch(32'h0000_3004);

    // Store answered with a bus error.
    do_data(1'b1, 64'hC0DE_0001_0000_100F, 64'h1122_3344_5566_7788, 3'b011, 1'b0);

    // Reset while the data grant is outstanding; ack in the release cycle is ignored.
    auto_ack = 1'b0;
    cur_d_we = 1'b0; cur_d_addr = 64'h5000_0000_0000_0040; cur_d_size = 3'b011; cur_d_signed = 1'b0;
    dmem_addr = cur_d_addr; dmem_size = 3'b011; dmem_signed = 1'b0; dmem_read_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = port_req;
    end
    check("rstd_grant_seen", seen, 1);
    reset = 1'b1; dmem_read_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; port_ack = 1'b1; port_rdata = 64'hBAD; port_err = 1'b1;
    @(negedge clk);
    check("rstd_port_req", port_req, 0);
    check("rstd_idle", imem_ready, 1);
    check("rstd_no_dmem_ready", dmem_ready, 0);
    @(posedge clk); #1; port_ack = 1'b0; port_err = 1'b0;
    @(negedge clk);
    check("rstd_ack_ignored", dmem_ready, 0);
    check("rstd_still_idle", imem_ready, 1);
    @(posedge clk); #1;
    auto_ack = 1'b1;

    // Randomized concurrent traffic.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_fetch($urandom);
        end
      end
      begin
        logic        dwe, dsg;
        logic [63:0] da, dwd;
        logic [2:0]  dsz;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          dwe = 1'($urandom_range(0, 1));
          dsg = 1'($urandom_range(0, 1));
          dsz = 3'($urandom_range(0, 7));
          da  = {($urandom | 32'h1), $urandom};
          dwd = {$urandom, $urandom};
          do_data(dwe, da, dwd, dsz, dsg);
        end
      end
    join

    repeat (10) @(posedge clk);
    check("exp_i_q_empty", exp_i_q.size(), 0);
    check("exp_d_q_empty", exp_d_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
